// File: rtl/acc_buf_pkg.sv
// Shared types and sizing helpers for the accelerator result buffer.
//   state_t      : burst FSM states
//   *_DEF        : default configuration (32-bit words, 8 entries, 4-word bursts)
//   cnt_width()  : occupancy counter width for a given depth (0..depth inclusive)
//   len_width()  : burst length field width for a given maximum burst (0..max inclusive)
package acc_buf_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned BURST_LEN_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned len_width(input int unsigned burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/acc_buf_fifo.sv
// First-word-fall-through FIFO: a word pushed at edge N is at the head after edge N.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous flush
//   push, din  : write strobe and entry (caller guarantees not full)
//   pop        : discard head (caller guarantees not empty)
//   head       : current head entry
//   count      : occupancy, 0..DEPTH
module acc_buf_fifo
  import acc_buf_pkg::*;
#(
  parameter int unsigned  WIDTH = DATA_WIDTH_DEF + 1,
  parameter int unsigned  DEPTH = DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/acc_result_buffer.sv
// Buffers accelerator results and streams them to the DMA in granted bursts.
//   wb_clk_i, wb_rst_i        : clock, async active-low reset
//   clr_i                     : synchronous flush (aborts any burst, no done pulses)
//   acc_vld_i/acc_rdy_o       : accelerator word handshake, acc_dat_i + acc_last_i
//   burst_req_o/burst_len_o   : burst request and its length, burst_gnt_i grants it
//   acc_data_valid_o/acc_data_o, dma_rdy_i : stream to the DMA with backpressure
//   burst_done_o, job_done_o  : one-cycle pulses after the final / last-tagged beat
//   fill_level_o              : FIFO occupancy
module acc_result_buffer
  import acc_buf_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned  DEPTH      = DEPTH_DEF,
  parameter int unsigned  BURST_LEN  = BURST_LEN_DEF,
  localparam int unsigned CNT_W      = cnt_width(DEPTH),
  localparam int unsigned LEN_W      = len_width(BURST_LEN)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  clr_i,
  input  logic                  acc_vld_i,
  output logic                  acc_rdy_o,
  input  logic [DATA_WIDTH-1:0] acc_dat_i,
  input  logic                  acc_last_i,
  output logic                  burst_req_o,
  output logic [LEN_W-1:0]      burst_len_o,
  input  logic                  burst_gnt_i,
  output logic                  acc_data_valid_o,
  output logic [DATA_WIDTH-1:0] acc_data_o,
  input  logic                  dma_rdy_i,
  output logic                  burst_done_o,
  output logic                  job_done_o,
  output logic [CNT_W-1:0]      fill_level_o
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  state_t             state;
  state_t             state_n;
  logic               run;
  logic               last_held;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   fill;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   remaining_n;
  logic [LEN_W-1:0]   len_n;
  logic               req_n;
  logic               valid_n;
  logic               burst_done_n;
  logic               job_done_n;

  // Input side: at most one job end may sit in the FIFO.
  assign acc_rdy_o = run && (fill < CNT_W'(DEPTH)) && !last_held && !clr_i;
  assign push      = acc_vld_i && acc_rdy_o;
  assign pop       = acc_data_valid_o && dma_rdy_i && !clr_i;

  acc_buf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .clr   (clr_i),
    .push  (push),
    .pop   (pop),
    .din   ({acc_last_i, acc_dat_i}),
    .head  (head),
    .count (fill)
  );

  assign fill_level_o = fill;
  // Gate the head so the stream bus reads zero whenever no beat is offered.
  assign acc_data_o   = acc_data_valid_o ? head[DATA_WIDTH-1:0] : '0;

  // Run flag and job-end tracking.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      run       <= 1'b0;
      last_held <= 1'b0;
    end else begin
      run <= 1'b1;
      if (clr_i)                          last_held <= 1'b0;
      else if (push && acc_last_i)        last_held <= 1'b1;
      else if (pop && head[DATA_WIDTH])   last_held <= 1'b0;
    end
  end

  // Burst FSM: next state and next registered outputs.
  always_comb begin
    state_n      = state;
    len_n        = burst_len_o;
    remaining_n  = remaining;
    req_n        = 1'b0;
    valid_n      = 1'b0;
    burst_done_n = 1'b0;
    job_done_n   = 1'b0;
    if (clr_i) begin
      state_n     = IDLE;
      remaining_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fill >= CNT_W'(BURST_LEN) || (last_held && fill != '0)) begin
            state_n = REQ;
            len_n   = (fill >= CNT_W'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(fill);
          end
        end
        REQ: begin
          // Grant is honoured only once the request is visible to the DMA.
          if (burst_req_o && burst_gnt_i) begin
            state_n     = XFER;
            remaining_n = burst_len_o;
            valid_n     = 1'b1;
          end else begin
            req_n = 1'b1;
          end
        end
        XFER: begin
          valid_n = 1'b1;
          if (pop) begin
            remaining_n = remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state_n      = IDLE;
              valid_n      = 1'b0;
              burst_done_n = 1'b1;
              job_done_n   = head[DATA_WIDTH];
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state            <= IDLE;
      remaining        <= '0;
      burst_len_o      <= '0;
      burst_req_o      <= 1'b0;
      acc_data_valid_o <= 1'b0;
      burst_done_o     <= 1'b0;
      job_done_o       <= 1'b0;
    end else begin
      state            <= state_n;
      remaining        <= remaining_n;
      burst_len_o      <= len_n;
      burst_req_o      <= req_n;
      acc_data_valid_o <= valid_n;
      burst_done_o     <= burst_done_n;
      job_done_o       <= job_done_n;
    end
  end

endmodule

// File: tb/tb_acc_result_buffer.sv
// Self-checking bench for acc_result_buffer: cycle vectors plus scoreboarded sequences.
module tb_acc_result_buffer;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          vld = 1'b0;
  logic          last = 1'b0;
  logic          gnt = 1'b0;
  logic          drdy = 1'b0;
  logic [DW-1:0] dat = '0;
  logic          rdy;
  logic          req;
  logic [LW-1:0] len;
  logic          valid;
  logic [DW-1:0] odat;
  logic          bdone;
  logic          jdone;
  logic [CW-1:0] fill;

  always #5 clk = ~clk;

  acc_result_buffer #(
    .DATA_WIDTH (32),
    .DEPTH      (8),
    .BURST_LEN  (4)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst_n),
    .clr_i            (clr),
    .acc_vld_i        (vld),
    .acc_rdy_o        (rdy),
    .acc_dat_i        (dat),
    .acc_last_i       (last),
    .burst_req_o      (req),
    .burst_len_o      (len),
    .burst_gnt_i      (gnt),
    .acc_data_valid_o (valid),
    .acc_data_o       (odat),
    .dma_rdy_i        (drdy),
    .burst_done_o     (bdone),
    .job_done_o       (jdone),
    .fill_level_o     (fill)
  );

  int checks = 0;
  int failures = 0;
  int bd_cnt = 0;
  int jd_cnt = 0;

  logic [DW-1:0] model[$];   // words expected in the FIFO, oldest first
  logic [DW:0]   src[$];     // {last, data} words still to offer

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rdy_e;
    logic       req_e;
    logic [2:0] len_e;
    logic       val_e;
    logic [7:0] dat_e;
    logic       bd_e;
    logic       jd_e;
    logic [3:0] fill_e;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic r, logic q, logic [2:0] ln,
                              logic va, logic [7:0] dd, logic b, logic j, logic [3:0] f);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.rdy_e = r; t.req_e = q; t.len_e = ln;
    t.val_e = va; t.dat_e = dd; t.bd_e = b; t.jd_e = j; t.fill_e = f;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with scoreboard: offers src, consumes beats, checks fill and stall stability.
  task automatic step();
    bit            stall;
    logic [DW-1:0] pd;
    if (src.size() > 0) begin
      vld = 1'b1;
      {last, dat} = src[0];
    end else begin
      vld = 1'b0;
      last = 1'b0;
    end
    #1;
    stall = valid && !drdy;
    pd = odat;
    if (valid && drdy && !clr) begin
      if (model.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_extra: got %0h expected no beat", odat);
      end else begin
        check("beat_data", 64'(odat), 64'(model.pop_front()));
      end
    end
    if (vld && rdy) begin
      model.push_back(dat);
      void'(src.pop_front());
    end
    @(posedge clk);
    #1;
    if (bdone) bd_cnt++;
    if (jdone) jd_cnt++;
    check("fill", 64'(fill), 64'(model.size()));
    if (stall) begin
      check("stall_valid", 64'(valid), 64'd1);
      check("stall_data", 64'(odat), 64'(pd));
    end
  endtask

  task automatic run_burst(input string name, input int max, input bit alt, output int vcyc);
    bit done;
    done = 1'b0;
    vcyc = 0;
    for (int c = 0; c < max && !done; c++) begin
      if (valid) begin
        drdy = alt ? (vcyc % 2 == 0) : 1'b1;
        vcyc++;
      end else begin
        drdy = 1'b1;
      end
      step();
      done = bdone;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s: burst_done not seen within %0d cycles", name, max);
    end
  endtask

  task automatic wait_valid(input string name, input int max);
    for (int c = 0; c < max && !valid; c++) step();
    check(name, 64'(valid), 64'd1);
  endtask

  initial begin
    int vc;
    int b0;
    int j0;

    // Reset and run flag
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {20'd0, rdy, req, len, valid, odat, bdone, jdone, fill}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("run_delay", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    check("run_set", 64'(rdy), 64'd1);

    // Cycle vectors: plain 4-word burst, then 3-word job ending on last tag
    tbl[0]  = mk(1, 8'h11, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[1]  = mk(1, 8'h12, 0, 1, 0, 0, 0, 8'h00, 0, 0, 2);
    tbl[2]  = mk(1, 8'h13, 0, 1, 0, 0, 0, 8'h00, 0, 0, 3);
    tbl[3]  = mk(1, 8'h14, 0, 1, 0, 0, 0, 8'h00, 0, 0, 4);
    tbl[4]  = mk(0, 8'h00, 0, 1, 0, 4, 0, 8'h00, 0, 0, 4);
    tbl[5]  = mk(0, 8'h00, 0, 1, 1, 4, 0, 8'h00, 0, 0, 4);
    tbl[6]  = mk(0, 8'h00, 0, 1, 0, 4, 1, 8'h11, 0, 0, 4);
    tbl[7]  = mk(0, 8'h00, 0, 1, 0, 4, 1, 8'h12, 0, 0, 3);
    tbl[8]  = mk(0, 8'h00, 0, 1, 0, 4, 1, 8'h13, 0, 0, 2);
    tbl[9]  = mk(0, 8'h00, 0, 1, 0, 4, 1, 8'h14, 0, 0, 1);
    tbl[10] = mk(0, 8'h00, 0, 1, 0, 4, 0, 8'h00, 1, 0, 0);
    tbl[11] = mk(0, 8'h00, 0, 1, 0, 4, 0, 8'h00, 0, 0, 0);
    tbl[12] = mk(1, 8'h21, 0, 1, 0, 4, 0, 8'h00, 0, 0, 1);
    tbl[13] = mk(1, 8'h22, 0, 1, 0, 4, 0, 8'h00, 0, 0, 2);
    tbl[14] = mk(1, 8'h23, 1, 0, 0, 4, 0, 8'h00, 0, 0, 3);
    tbl[15] = mk(0, 8'h00, 0, 0, 0, 3, 0, 8'h00, 0, 0, 3);
    tbl[16] = mk(0, 8'h00, 0, 0, 1, 3, 0, 8'h00, 0, 0, 3);
    tbl[17] = mk(0, 8'h00, 0, 0, 0, 3, 1, 8'h21, 0, 0, 3);
    tbl[18] = mk(0, 8'h00, 0, 0, 0, 3, 1, 8'h22, 0, 0, 2);
    tbl[19] = mk(0, 8'h00, 0, 0, 0, 3, 1, 8'h23, 0, 0, 1);
    tbl[20] = mk(0, 8'h00, 0, 1, 0, 3, 0, 8'h00, 1, 1, 0);
    tbl[21] = mk(0, 8'h00, 0, 1, 0, 3, 0, 8'h00, 0, 0, 0);
    gnt = 1'b1;
    drdy = 1'b1;
    for (int i = 0; i < 22; i++) begin
      vld = tbl[i].v;
      dat = 32'(tbl[i].d);
      last = tbl[i].l;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {20'd0, rdy, req, len, valid, odat, bdone, jdone, fill},
            {20'd0, tbl[i].rdy_e, tbl[i].req_e, tbl[i].len_e, tbl[i].val_e, 32'(tbl[i].dat_e),
             tbl[i].bd_e, tbl[i].jd_e, tbl[i].fill_e});
    end
    vld = 1'b0;
    last = 1'b0;
    gnt = 1'b0;

    // Fill to full without grant, then keep pushing while bursts drain
    for (int w = 0; w < 12; w++) src.push_back({1'b0, 32'h31 + 32'(w)});
    drdy = 1'b1;
    b0 = bd_cnt;
    j0 = jd_cnt;
    repeat (12) step();
    check("full_fill", 64'(fill), 64'd8);
    check("full_rdy", 64'(rdy), 64'd0);
    check("held_words", 64'(src.size()), 64'd4);
    check("full_req", 64'(req), 64'd1);
    check("full_len", 64'(len), 64'd4);
    gnt = 1'b1;
    run_burst("burst_a", 20, 1'b0, vc);
    gnt = 1'b0;
    for (int c = 0; c < 6 && !req; c++) step();
    check("req_b", 64'(req), 64'd1);
    check("len_b", 64'(len), 64'd4);
    gnt = 1'b1;
    run_burst("burst_b", 20, 1'b0, vc);
    gnt = 1'b0;
    check("bursts_ab", 64'(bd_cnt - b0), 64'd2);
    check("jobs_ab", 64'(jd_cnt - j0), 64'd0);
    // Flush leftovers
    src.delete();
    vld = 1'b0;
    drdy = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model.delete();
    check("flush_fill", 64'(fill), 64'd0);
    check("flush_req", 64'(req), 64'd0);

    // Alternating DMA ready: 4 beats over 7 valid cycles
    for (int w = 0; w < 4; w++) src.push_back({1'b0, 32'h41 + 32'(w)});
    gnt = 1'b1;
    run_burst("stall_burst", 40, 1'b1, vc);
    gnt = 1'b0;
    check("xfer_cycles", 64'(vc), 64'd7);

    // clr in the middle of a last-tagged burst
    src.push_back({1'b0, 32'h51});
    src.push_back({1'b0, 32'h52});
    src.push_back({1'b1, 32'h53});
    gnt = 1'b1;
    drdy = 1'b1;
    wait_valid("clr_wait", 20);
    step();
    check("clr_len", 64'(len), 64'd3);
    drdy = 1'b0;
    clr = 1'b1;
    #1;
    check("clr_rdy", 64'(rdy), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    model.delete();
    check("clr_drop", {60'd0, valid, req, bdone, jdone}, 64'd0);
    check("clr_fill", 64'(fill), 64'd0);
    b0 = bd_cnt;
    j0 = jd_cnt;
    gnt = 1'b0;
    drdy = 1'b1;
    repeat (4) step();
    check("clr_no_done", 64'(bd_cnt - b0 + jd_cnt - j0), 64'd0);
    check("clr_rdy_back", 64'(rdy), 64'd1);

    // Asynchronous reset in the middle of a burst
    for (int w = 0; w < 4; w++) src.push_back({1'b0, 32'h61 + 32'(w)});
    gnt = 1'b1;
    wait_valid("rst_wait", 20);
    step();
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", {26'd0, rdy, req, valid, odat, fill}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_no_done", {62'd0, bdone, jdone}, 64'd0);
    rst_n = 1'b1;
    src.delete();
    model.delete();
    gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_recover", {59'd0, rdy, fill}, {59'd0, 1'b1, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
